// File: rtl/ndn_pkg.sv
// Shared NDN router definitions: field widths, the PIT entry layout and the
// control-state encoding used by pit_table and the fib FSMs.
package ndn_pkg;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;

    // The face bitmap lives beside each entry because its width follows FACES.
    typedef struct packed {
        logic                valid;
        logic [PREFIX_W-1:0] prefix;
        logic [LEN_W-1:0]    len;
    } pit_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_I_SCAN,
        ST_I_FWD,
        ST_D_SCAN,
        ST_D_XFER
    } ndn_state_e;

endpackage

// File: rtl/pit_match.sv
// Compares one PIT entry against a probe prefix/length; shared by the
// interest and data scans.
module pit_match
    import ndn_pkg::*;
(
    input  logic                entry_valid,
    input  logic [PREFIX_W-1:0] entry_prefix,
    input  logic [LEN_W-1:0]    entry_len,
    input  logic [PREFIX_W-1:0] probe_prefix,
    input  logic [LEN_W-1:0]    probe_len,
    output logic                hit,
    output logic                free
);

    assign hit  = entry_valid && (entry_prefix == probe_prefix) && (entry_len == probe_len);
    assign free = !entry_valid;

endmodule

// File: rtl/pit_table.sv
// Pending Interest Table: aggregates interests, forwards new ones to the FIB
// and streams returning data to every face that asked for it.
module pit_table
    import ndn_pkg::*;
#(
    parameter int ENTRIES    = 8,
    parameter int FACES      = 4,
    parameter int DATA_BYTES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                interest_valid,
    output logic                interest_ready,
    input  logic [PREFIX_W-1:0] interest_prefix,
    input  logic [LEN_W-1:0]    interest_len,
    input  logic [1:0]          interest_face,
    output logic                interest_dropped,
    output logic [PREFIX_W-1:0] pit_in_prefix,
    output logic [LEN_W-1:0]    pit_in_len,
    output logic                fib_out_bit,
    input  logic [PREFIX_W-1:0] pit_out_prefix,
    input  logic [LEN_W-1:0]    pit_out_len,
    input  logic                prefix_ready,
    output logic                start_send_to_pit,
    output logic                rejected,
    input  logic [7:0]          out_data,
    output logic [7:0]          data_out,
    output logic                data_out_valid,
    output logic [FACES-1:0]    data_faces
);

    localparam int               IDX_W     = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);
    localparam logic [9:0]       LAST_BYTE = 10'(DATA_BYTES - 1);

    ndn_state_e state, state_next;

    pit_entry_t       entries     [ENTRIES];
    logic [FACES-1:0] entry_faces [ENTRIES];

    logic [IDX_W-1:0]    idx, hit_idx, free_idx, x_idx, hit_sel, free_sel;
    logic                hit_found, free_found, hit_any, free_any;
    logic                cur_hit, cur_free;
    logic                scanning, scan_last, i_end, d_end, take_interest;
    logic [PREFIX_W-1:0] i_prefix, d_prefix, probe_prefix;
    logic [LEN_W-1:0]    i_len, d_len, probe_len;
    logic [1:0]          i_face;
    logic                d_pending;
    logic [9:0]          byte_cnt;
    logic [FACES-1:0]    face_bit;

    // A data request (pending or arriving right now) outranks a waiting interest.
    assign interest_ready = rst && (state == ST_IDLE) && !d_pending && !prefix_ready;
    assign take_interest  = interest_ready && interest_valid;

    assign scanning     = (state == ST_I_SCAN) || (state == ST_D_SCAN);
    assign scan_last    = (idx == LAST_IDX);
    assign i_end        = (state == ST_I_SCAN) && scan_last;
    assign d_end        = (state == ST_D_SCAN) && scan_last;
    assign probe_prefix = (state == ST_D_SCAN) ? d_prefix : i_prefix;
    assign probe_len    = (state == ST_D_SCAN) ? d_len : i_len;
    assign face_bit     = FACES'(1) << i_face;

    assign data_out_valid = (state == ST_D_XFER);
    assign data_out       = (state == ST_D_XFER) ? out_data : '0;

    pit_match u_match (
        .entry_valid  (entries[idx].valid),
        .entry_prefix (entries[idx].prefix),
        .entry_len    (entries[idx].len),
        .probe_prefix (probe_prefix),
        .probe_len    (probe_len),
        .hit          (cur_hit),
        .free         (cur_free)
    );

    // Fold the entry under the cursor into what the scan has seen so far.
    always_comb begin
        hit_any  = hit_found || cur_hit;
        hit_sel  = cur_hit ? idx : hit_idx;
        free_any = free_found || cur_free;
        free_sel = free_found ? free_idx : idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (d_pending || prefix_ready) begin
                    state_next = ST_D_SCAN;
                end else if (take_interest) begin
                    state_next = ST_I_SCAN;
                end
            end
            ST_I_SCAN: begin
                if (scan_last) begin
                    state_next = (!hit_any && free_any) ? ST_I_FWD : ST_IDLE;
                end
            end
            ST_I_FWD:  state_next = ST_IDLE;
            ST_D_SCAN: begin
                if (scan_last) begin
                    state_next = hit_any ? ST_D_XFER : ST_IDLE;
                end
            end
            ST_D_XFER: begin
                if (byte_cnt == LAST_BYTE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx               <= '0;
            hit_found         <= 1'b0;
            hit_idx           <= '0;
            free_found        <= 1'b0;
            free_idx          <= '0;
            i_prefix          <= '0;
            i_len             <= '0;
            i_face            <= '0;
            d_pending         <= 1'b0;
            d_prefix          <= '0;
            d_len             <= '0;
            x_idx             <= '0;
            byte_cnt          <= '0;
            pit_in_prefix     <= '0;
            pit_in_len        <= '0;
            data_faces        <= '0;
            fib_out_bit       <= 1'b0;
            interest_dropped  <= 1'b0;
            start_send_to_pit <= 1'b0;
            rejected          <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i]     <= '0;
                entry_faces[i] <= '0;
            end
        end else begin
            fib_out_bit       <= (state == ST_I_FWD);
            interest_dropped  <= i_end && !hit_any && !free_any;
            start_send_to_pit <= d_end && hit_any;
            rejected          <= d_end && !hit_any;

            // The FIB holds off its next request until it sees accept/reject.
            if (prefix_ready) begin
                d_pending <= 1'b1;
                d_prefix  <= pit_out_prefix;
                d_len     <= pit_out_len;
            end else if (d_end) begin
                d_pending <= 1'b0;
            end

            if (scanning) begin
                idx <= idx + IDX_W'(1);
                if (cur_hit) begin
                    hit_found <= 1'b1;
                    hit_idx   <= idx;
                end
                if (cur_free && !free_found) begin
                    free_found <= 1'b1;
                    free_idx   <= idx;
                end
            end else begin
                idx        <= '0;
                hit_found  <= 1'b0;
                free_found <= 1'b0;
            end

            if (take_interest) begin
                i_prefix <= interest_prefix;
                i_len    <= interest_len;
                i_face   <= interest_face;
            end

            if (i_end) begin
                if (hit_any) begin
                    entry_faces[hit_sel] <= entry_faces[hit_sel] | face_bit;
                end else if (free_any) begin
                    entries[free_sel]     <= '{valid: 1'b1, prefix: i_prefix, len: i_len};
                    entry_faces[free_sel] <= face_bit;
                end
            end

            if (state == ST_I_FWD) begin
                pit_in_prefix <= i_prefix;
                pit_in_len    <= i_len;
            end

            if (d_end && hit_any) begin
                data_faces <= entry_faces[hit_sel];
                x_idx      <= hit_sel;
            end

            if (state == ST_D_XFER) begin
                byte_cnt <= byte_cnt + 10'd1;
                if (byte_cnt == LAST_BYTE) begin
                    entries[x_idx].valid <= 1'b0;
                end
            end else begin
                byte_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pit_table.sv
// Randomized bench for pit_table: a table-level model schedules the expected
// pulses and bytes per cycle, and one process compares them every cycle.
module tb_pit_table;

    localparam int ENT    = 8;
    localparam int NBYTES = 1024;
    localparam int K_FWD  = 0;
    localparam int K_AGG  = 1;
    localparam int K_DROP = 2;
    localparam int K_ACC  = 3;
    localparam int K_REJ  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        interest_valid = 1'b0;
    logic        interest_ready;
    logic [63:0] interest_prefix = '0;
    logic [5:0]  interest_len = '0;
    logic [1:0]  interest_face = '0;
    logic        interest_dropped;
    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        fib_out_bit;
    logic [63:0] pit_out_prefix = '0;
    logic [5:0]  pit_out_len = '0;
    logic        prefix_ready = 1'b0;
    logic        start_send_to_pit;
    logic        rejected;
    logic [7:0]  out_data = '0;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic [3:0]  data_faces;

    always #5 clk = ~clk;

    pit_table dut (
        .clk               (clk),
        .rst               (rst),
        .interest_valid    (interest_valid),
        .interest_ready    (interest_ready),
        .interest_prefix   (interest_prefix),
        .interest_len      (interest_len),
        .interest_face     (interest_face),
        .interest_dropped  (interest_dropped),
        .pit_in_prefix     (pit_in_prefix),
        .pit_in_len        (pit_in_len),
        .fib_out_bit       (fib_out_bit),
        .pit_out_prefix    (pit_out_prefix),
        .pit_out_len       (pit_out_len),
        .prefix_ready      (prefix_ready),
        .start_send_to_pit (start_send_to_pit),
        .rejected          (rejected),
        .out_data          (out_data),
        .data_out          (data_out),
        .data_out_valid    (data_out_valid),
        .data_faces        (data_faces)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dv_seen = 0;
    int xfer_start = -100000;
    bit cmp_on = 0;

    logic        m_valid  [ENT];
    logic [63:0] m_prefix [ENT];
    logic [5:0]  m_len    [ENT];
    logic [3:0]  m_faces  [ENT];

    bit          busy       [int];
    bit          exp_fib    [int];
    logic [63:0] exp_pfx    [int];
    logic [5:0]  exp_len    [int];
    bit          exp_drop   [int];
    bit          exp_start  [int];
    bit          exp_rej    [int];
    logic [7:0]  exp_byte   [int];
    logic [3:0]  exp_dfaces [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #2;
        if (cyc >= xfer_start && cyc < xfer_start + NBYTES) out_data = 8'((cyc - xfer_start) & 255);
        else out_data = 8'($urandom);
    endtask

    task automatic reset_model();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_prefix[i] = '0;
            m_len[i] = '0;
            m_faces[i] = '0;
        end
        busy.delete();
        exp_fib.delete();
        exp_pfx.delete();
        exp_len.delete();
        exp_drop.delete();
        exp_start.delete();
        exp_rej.delete();
        exp_byte.delete();
        exp_dfaces.delete();
        xfer_start = -100000;
    endtask

    task automatic do_reset();
        interest_valid = 1'b0;
        rst = 1'b0;
        reset_model();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Interest semantics: aggregate onto a match, else take the lowest free slot, else drop.
    task automatic send_interest(input logic [63:0] p, input logic [5:0] l, input logic [1:0] f,
                                 output int kind);
        int a, hit, fr;
        a = cyc + 1;
        hit = -1;
        fr = -1;
        for (int i = 0; i < ENT; i++) begin
            if (m_valid[i] && m_prefix[i] == p && m_len[i] == l) hit = i;
            if (!m_valid[i] && fr < 0) fr = i;
        end
        for (int k = 0; k < ENT; k++) busy[a + k] = 1'b1;
        if (hit >= 0) begin
            m_faces[hit] = m_faces[hit] | 4'(1 << f);
            kind = K_AGG;
        end else if (fr >= 0) begin
            m_valid[fr] = 1'b1;
            m_prefix[fr] = p;
            m_len[fr] = l;
            m_faces[fr] = 4'(1 << f);
            busy[a + ENT] = 1'b1;
            exp_fib[a + ENT + 1] = 1'b1;
            exp_pfx[a + ENT + 1] = p;
            exp_len[a + ENT + 1] = l;
            kind = K_FWD;
        end else begin
            exp_drop[a + ENT] = 1'b1;
            kind = K_DROP;
        end
        interest_valid = 1'b1;
        interest_prefix = p;
        interest_len = l;
        interest_face = f;
        tick();
        interest_valid = 1'b0;
        while (cyc < a + ((kind == K_FWD) ? ENT + 1 : ENT)) tick();
    endtask

    // Data semantics: a match streams NBYTES to its faces and frees the entry, else reject.
    task automatic request_data(input logic [63:0] p, input logic [5:0] l, input int abort_byte,
                                output int kind);
        int c, x, hit, stop;
        bit aborted;
        c = cyc;
        x = c + ENT + 1;
        hit = -1;
        aborted = 0;
        for (int i = 0; i < ENT; i++)
            if (m_valid[i] && m_prefix[i] == p && m_len[i] == l) hit = i;
        if (hit >= 0) begin
            for (int k = c; k < x + NBYTES; k++) busy[k] = 1'b1;
            exp_start[x] = 1'b1;
            for (int k = 0; k < NBYTES; k++) begin
                exp_byte[x + k] = 8'(k & 255);
                exp_dfaces[x + k] = m_faces[hit];
            end
            m_valid[hit] = 1'b0;
            xfer_start = x;
            kind = K_ACC;
            stop = x + NBYTES;
        end else begin
            for (int k = c; k < x; k++) busy[k] = 1'b1;
            exp_rej[x] = 1'b1;
            kind = K_REJ;
            stop = x;
        end
        prefix_ready = 1'b1;
        pit_out_prefix = p;
        pit_out_len = l;
        tick();
        prefix_ready = 1'b0;
        while (!aborted && cyc < stop) begin
            tick();
            if (cyc == x) check("resp_pulse", 64'(kind == K_ACC ? start_send_to_pit : rejected), 64'd1);
            if (abort_byte >= 0 && kind == K_ACC && cyc == x + abort_byte) begin
                do_reset();
                aborted = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("interest_ready", 64'(interest_ready), 64'(rst && !busy.exists(cyc)));
            check("fib_out_bit", 64'(fib_out_bit), 64'(exp_fib.exists(cyc)));
            if (exp_fib.exists(cyc)) begin
                check("pit_in_prefix", pit_in_prefix, exp_pfx[cyc]);
                check("pit_in_len", 64'(pit_in_len), 64'(exp_len[cyc]));
            end else if (!rst) begin
                check("pit_in_prefix_rst", pit_in_prefix, 64'd0);
                check("pit_in_len_rst", 64'(pit_in_len), 64'd0);
            end
            check("interest_dropped", 64'(interest_dropped), 64'(exp_drop.exists(cyc)));
            check("start_send_to_pit", 64'(start_send_to_pit), 64'(exp_start.exists(cyc)));
            check("rejected", 64'(rejected), 64'(exp_rej.exists(cyc)));
            check("data_out_valid", 64'(data_out_valid), 64'(exp_byte.exists(cyc)));
            if (exp_byte.exists(cyc)) begin
                check("data_out", 64'(data_out), 64'(exp_byte[cyc]));
                check("data_faces", 64'(data_faces), 64'(exp_dfaces[cyc]));
            end else begin
                check("data_out_idle", 64'(data_out), 64'd0);
            end
            if (!rst) check("data_faces_rst", 64'(data_faces), 64'd0);
            if (data_out_valid) dv_seen++;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind, dv0, sel;
        logic [63:0] pool_p [6];
        logic [5:0]  pool_l [6];

        #1 rst = 1'b0;
        reset_model();
        cmp_on = 1;
        tick();
        tick();
        check("rst_ready", 64'(interest_ready), 64'd0);
        check("rst_dv", 64'(data_out_valid), 64'd0);
        check("rst_pit_in", pit_in_prefix, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] new interest is forwarded");
        send_interest(64'hA5A5_0000_0000_0000, 6'd16, 2'd1, kind);
        check("model_fwd", 64'(kind), 64'(K_FWD));
        check("lit_fib", 64'(fib_out_bit), 64'd1);
        check("lit_pit_prefix", pit_in_prefix, 64'hA5A5_0000_0000_0000);
        check("lit_pit_len", 64'(pit_in_len), 64'd16);

        $display("[TB] matching interest is aggregated");
        send_interest(64'hA5A5_0000_0000_0000, 6'd16, 2'd3, kind);
        check("model_agg", 64'(kind), 64'(K_AGG));
        check("model_faces0", 64'(m_faces[0]), 64'h0A);
        check("lit_no_fwd", 64'(fib_out_bit), 64'd0);
        check("lit_pit_hold", pit_in_prefix, 64'hA5A5_0000_0000_0000);

        $display("[TB] fill the table, then overflow");
        for (int i = 1; i < ENT; i++) send_interest(64'h1000_0000_0000_0000 + 64'(i * 17), 6'd32, 2'(i), kind);
        send_interest(64'hDEAD_BEEF_0000_0000, 6'd8, 2'd0, kind);
        check("model_drop", 64'(kind), 64'(K_DROP));
        check("lit_drop", 64'(interest_dropped), 64'd1);

        $display("[TB] data for entry 0");
        dv0 = dv_seen;
        request_data(64'hA5A5_0000_0000_0000, 6'd16, -1, kind);
        check("model_acc", 64'(kind), 64'(K_ACC));
        check("lit_bytes", 64'(dv_seen - dv0), 64'(NBYTES));
        check("lit_data_faces", 64'(data_faces), 64'h0A);
        request_data(64'hA5A5_0000_0000_0000, 6'd16, -1, kind);
        check("model_freed", 64'(kind), 64'(K_REJ));

        $display("[TB] unknown data prefix");
        dv0 = dv_seen;
        request_data(64'h0123_4567_89AB_CDEF, 6'd40, -1, kind);
        check("model_rej", 64'(kind), 64'(K_REJ));
        check("lit_no_bytes", 64'(dv_seen - dv0), 64'd0);

        $display("[TB] simultaneous interest and data, reset mid-transfer");
        send_interest(64'hBEEF_0000_0000_0001, 6'd24, 2'd2, kind);
        interest_valid = 1'b1;
        interest_prefix = 64'hCAFE_0000_0000_0002;
        interest_len = 6'd20;
        interest_face = 2'd0;
        request_data(64'hBEEF_0000_0000_0001, 6'd24, 500, kind);
        check("lit_post_rst_dv", 64'(data_out_valid), 64'd0);
        check("lit_post_rst_faces", 64'(data_faces), 64'd0);
        check("lit_post_rst_pit", pit_in_prefix, 64'd0);
        send_interest(64'hBEEF_0000_0000_0001, 6'd24, 2'd2, kind);
        check("model_refwd", 64'(kind), 64'(K_FWD));
        check("lit_refwd", 64'(fib_out_bit), 64'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 6; i++) begin
            pool_p[i] = {$urandom, $urandom};
            pool_l[i] = 6'($urandom_range(1, 63));
        end
        pool_p[4] = pool_p[0];
        pool_l[4] = pool_l[0] ^ 6'd1;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 5);
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 9) < 6) send_interest(pool_p[sel], pool_l[sel], 2'($urandom_range(0, 3)), kind);
            else request_data(pool_p[sel], pool_l[sel], -1, kind);
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pit_table.md
# pit_table

Pending Interest Table for the NDN router, sitting directly between the interfaces and the `fib` stage. It records outstanding interests as prefix, length and a requesting-face bitmap. New interests are forwarded to the FIB for longest-prefix routing; interests that match an existing entry are aggregated. When the FIB presents a returning data prefix, the table accepts it (`start_send_to_pit`) or rejects it (`rejected`), then streams the 1024 data bytes to the requesting faces and frees the entry.

## Interface
Parameters:
- `ENTRIES`, default 8: PIT depth, power of two.
- `FACES`, default 4: number of interfaces; width of the face bitmap.
- `DATA_BYTES`, default 1024: payload bytes per data packet.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `interest_valid` in 1: interest offered by an interface.
- `interest_ready` out 1: table can accept an interest this cycle.
- `interest_prefix` in 64: interest name prefix.
- `interest_len` in 6: interest prefix length.
- `interest_face` in 2: index of the arrival face.
- `interest_dropped` out 1: 1-cycle pulse when the table is full.
- `pit_in_prefix` out 64: prefix forwarded to the FIB.
- `pit_in_len` out 6: length forwarded to the FIB.
- `fib_out_bit` out 1: 1-cycle pulse telling the FIB to route.
- `pit_out_prefix` in 64: data prefix from the FIB.
- `pit_out_len` in 6: data prefix length from the FIB.
- `prefix_ready` in 1: 1-cycle pulse marking a data-prefix lookup request.
- `start_send_to_pit` out 1: 1-cycle pulse, data accepted.
- `rejected` out 1: 1-cycle pulse, no pending interest for this data.
- `out_data` in 8: data byte from the FIB.
- `data_out` out 8: byte forwarded to the faces.
- `data_out_valid` out 1: `data_out` is valid.
- `data_faces` out FACES: destination bitmap, held for the whole transfer.

## Operation
- Entry fields: `valid`, `prefix[63:0]`, `len[5:0]`, `faces[FACES-1:0]`.
- Match rule: `valid` and `prefix` equal and `len` equal.
- States:
  - IDLE
  - I_SCAN: interest lookup.
  - I_FWD: forward new interest to the FIB.
  - D_SCAN: data lookup.
  - D_XFER: stream data to faces.
- Data-prefix capture:
  - `prefix_ready` is a pulse and is captured in a pending register in any state.
  - Prefix and length are latched with it.
  - The FIB issues no second request until it sees accept or reject, so one pending slot is enough.
- IDLE:
  - A pending data request takes priority and moves to D_SCAN.
  - Otherwise `interest_ready` is 1. On `interest_valid` the interest fields are latched and the FSM moves to I_SCAN.
  - `interest_ready` is 0 in every other state.
- I_SCAN:
  - Index counter runs 0..ENTRIES-1, examining one entry per cycle.
  - The lowest free index seen is remembered.
  - On a match: OR the face bit into the entry's `faces`, return to IDLE, no forward (aggregation).
  - End of scan with no match and a free slot: write the entry with `faces` = one-hot of the arrival face, go to I_FWD.
  - End of scan with no match and no free slot: pulse `interest_dropped`, return to IDLE.
- I_FWD: `fib_out_bit`=1 for one cycle with `pit_in_prefix`/`pit_in_len`, then IDLE.
- D_SCAN:
  - Scans in the same way as I_SCAN.
  - On a match: pulse `start_send_to_pit`, latch `data_faces` and the index, clear the pending flag, go to D_XFER.
  - End of scan with no match: pulse `rejected`, clear the pending flag, go to IDLE.
- D_XFER:
  - Byte counter is 10 bits wide, zeroed on entry.
  - Each cycle: `data_out` = `out_data`, `data_out_valid`=1, counter +1.
  - When the counter equals DATA_BYTES-1 (that byte is still sent), clear the entry's `valid` and go to IDLE.
- Simultaneous events:
  - An interest and a data request in the same cycle in IDLE: data wins and the interest waits.
  - A matching interest arriving during D_XFER waits for IDLE. It then allocates a fresh entry, because the old entry is already freed.

## Timing
- Reset values:
  - All outputs 0.
  - All entries invalid.
  - Pending flag clear.
  - State IDLE.
- Interest latency:
  - Acceptance to `fib_out_bit` pulse is ENTRIES+1 cycles (9 at default).
  - Aggregation or drop completes ENTRIES cycles after acceptance.
- Data latency:
  - `prefix_ready` to accept or reject is at most ENTRIES+2 cycles.
  - The transfer then occupies exactly DATA_BYTES cycles.
- A reset asserted mid-transfer aborts it immediately. `data_out_valid` drops asynchronously and the table is cleared.
- `pit_in_*` and `data_faces` are registered and hold their value outside their strobe.

## Structure
- Shared package `ndn_pkg` holds:
  - `PREFIX_W`=64 and `LEN_W`=6.
  - `pit_entry_t` struct.
  - The state enum, also reused by the `fib` FSMs.
- One sub-module, `pit_match`: combinational compare of one entry against a probe prefix and length. It returns `hit` and `free`, and is used by both scans.

## Test plan
- Reset, then interest `0xA5A5_0000_0000_0000`/len 16 on face 1 → `fib_out_bit` pulse at acceptance+9 with the same prefix and length; entry 0 has faces=4'b0010.
- Same prefix from face 3 → no `fib_out_bit`; entry 0 faces=4'b1010.
- Fill all 8 entries with distinct prefixes, then a ninth interest → `interest_dropped` pulse, no forward.
- `prefix_ready` with the entry-0 prefix → `start_send_to_pit`; 1024 bytes 0..255 repeating appear on `data_out` with `data_faces`=4'b1010; entry 0 invalid afterwards.
- `prefix_ready` with an unknown prefix → `rejected` within 10 cycles, no `data_out_valid`.
- `interest_valid` and `prefix_ready` in the same IDLE cycle, then reset at byte 500 of the transfer → data is served first; after reset all outputs are 0 and a re-sent interest forwards anew.
